// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter stage.
// Strobes from the sequence controller are active-low.
package pc_unit_pkg;

  localparam logic [1:0] PCSRC_BRANCH = 2'b00;
  localparam logic [1:0] PCSRC_RETURN = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_VECTOR = 2'b11;

  localparam logic BRA_ABS = 1'b0;
  localparam logic BRA_REL = 1'b1;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  typedef struct packed {
    logic rst;
    logic ld;
    logic inc;
    logic push;
    logic pop;
  } pc_req_t;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Hardware return-address stack with push/pop/swap
// and a sticky overflow/underflow error flag.
module return_stack
  import pc_unit_pkg::*;
#(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned StackDepth = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 clr,
  output logic [DataWidth-1:0] top,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam int unsigned AW =
    (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DataWidth-1:0] mem [StackDepth];
  logic [CW-1:0]        depth;
  logic [CW-1:0]        depth_next;
  logic                 err_next;
  logic                 wr_en;
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        top_idx;
  logic [AW-1:0]        push_idx;

  logic do_clr;
  logic do_swap;
  logic do_pop;
  logic do_push;

  assign push_idx = depth[AW-1:0];
  assign top_idx  = depth[AW-1:0] - AW'(1);

  assign empty = (depth == '0);
  assign full  = (depth == CW'(StackDepth));
  assign top   = empty ? '0 : mem[top_idx];

  assign do_clr  = clr;
  assign do_swap = !clr && push && pop;
  assign do_pop  = !clr && pop && !push;
  assign do_push = !clr && push && !pop;

  always_comb begin
    depth_next = depth;
    err_next   = err;
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    unique case (1'b1)
      do_clr: begin
        depth_next = '0;
        err_next   = 1'b0;
      end
      do_swap: begin
        // Swap on empty: underflow, then the push lands in slot 0.
        wr_en = 1'b1;
        if (empty) begin
          err_next   = 1'b1;
          wr_idx     = push_idx;
          depth_next = CW'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      do_pop: begin
        if (empty) begin
          err_next = 1'b1;
        end else begin
          depth_next = depth - CW'(1);
        end
      end
      do_push: begin
        if (full) begin
          err_next = 1'b1;
        end else begin
          wr_en      = 1'b1;
          wr_idx     = push_idx;
          depth_next = depth + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      depth <= depth_next;
      err   <= err_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(StackDepth); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, branch target
// adder, source mux and return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned OffsetWidth = 10,
  parameter int unsigned StackDepth  = 4,
  parameter int unsigned ResetVector = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PC_Rst,
  input  logic                 PC_Inc,
  input  logic                 PC_Ld,
  input  logic [1:0]           PC_Src,
  input  logic                 BRA_Src,
  input  logic                 STK_Ld,
  input  logic [DataWidth-1:0] IR,
  input  logic [DataWidth-1:0] Reg_Src1,
  output logic [DataWidth-1:0] PC,
  output logic [DataWidth-1:0] STK_Top,
  output logic                 STK_Full,
  output logic                 STK_Empty,
  output logic                 STK_Err
);

  localparam logic [DataWidth-1:0] RV =
    DataWidth'(ResetVector);
  localparam int unsigned XW = DataWidth - OffsetWidth;

  pc_req_t              req;
  logic [OffsetWidth-1:0] offset;
  logic [DataWidth-1:0] offset_sext;
  logic [DataWidth-1:0] offset_zext;
  logic [DataWidth-1:0] branch_tgt;
  logic [DataWidth-1:0] return_tgt;
  logic [DataWidth-1:0] load_tgt;
  logic [DataWidth-1:0] pc_next;
  logic                 unused_ir;

  assign req.rst  = (PC_Rst == ASSERTED);
  assign req.ld   = !req.rst && (PC_Ld == ASSERTED);
  assign req.inc  = !req.rst && !req.ld
                 && (PC_Inc == ASSERTED);
  assign req.pop  = req.ld && (PC_Src == PCSRC_RETURN);
  assign req.push = !req.rst && (STK_Ld == ASSERTED);

  assign offset      = IR[OffsetWidth-1:0];
  assign unused_ir   = ^IR[DataWidth-1:OffsetWidth];
  assign offset_sext = {{XW{offset[OffsetWidth-1]}}, offset};
  assign offset_zext = {{XW{1'b0}}, offset};

  // PC already points past the branch, so no extra adjust.
  assign branch_tgt = (BRA_Src == BRA_REL)
                    ? PC + offset_sext
                    : offset_zext;

  assign return_tgt = STK_Empty ? RV : STK_Top;

  always_comb begin
    load_tgt = RV;
    unique case (PC_Src)
      PCSRC_BRANCH: load_tgt = branch_tgt;
      PCSRC_RETURN: load_tgt = return_tgt;
      PCSRC_REG:    load_tgt = Reg_Src1;
      PCSRC_VECTOR: load_tgt = RV;
      default:      load_tgt = RV;
    endcase
  end

  always_comb begin
    pc_next = PC;
    unique case (1'b1)
      req.rst: pc_next = RV;
      req.ld:  pc_next = load_tgt;
      req.inc: pc_next = PC + DataWidth'(1);
      default: pc_next = PC;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC <= RV;
    end else begin
      PC <= pc_next;
    end
  end

  return_stack #(
    .DataWidth (DataWidth),
    .StackDepth(StackDepth)
  ) u_stack (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (req.push),
    .pop      (req.pop),
    .push_data(PC),
    .clr      (req.rst),
    .top      (STK_Top),
    .full     (STK_Full),
    .empty    (STK_Empty),
    .err      (STK_Err)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios
// plus random strobes against a queue-based model.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int SD = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PC_Rst = 1'b1;
  logic        PC_Inc = 1'b1;
  logic        PC_Ld = 1'b1;
  logic [1:0]  PC_Src = 2'b00;
  logic        BRA_Src = 1'b0;
  logic        STK_Ld = 1'b1;
  logic [15:0] IR = '0;
  logic [15:0] Reg_Src1 = '0;
  logic [15:0] PC;
  logic [15:0] STK_Top;
  logic        STK_Full;
  logic        STK_Empty;
  logic        STK_Err;

  pc_unit #(
    .DataWidth  (16),
    .OffsetWidth(10),
    .StackDepth (SD),
    .ResetVector(0)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PC_Rst   (PC_Rst),
    .PC_Inc   (PC_Inc),
    .PC_Ld    (PC_Ld),
    .PC_Src   (PC_Src),
    .BRA_Src  (BRA_Src),
    .STK_Ld   (STK_Ld),
    .IR       (IR),
    .Reg_Src1 (Reg_Src1),
    .PC       (PC),
    .STK_Top  (STK_Top),
    .STK_Full (STK_Full),
    .STK_Empty(STK_Empty),
    .STK_Err  (STK_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] top;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_err;

  task automatic push_exp(input string nm);
    exp_t e;
    e.pc    = m_pc;
    e.top   = (m_stk.size() > 0) ? m_stk[$] : 16'h0;
    e.full  = (m_stk.size() == SD);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic model_reset();
    m_pc  = 16'h0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step(
    input bit rst, input bit inc, input bit ld,
    input bit stk, input logic [1:0] src,
    input bit bra, input logic [15:0] ir,
    input logic [15:0] r1);
    logic [15:0] old;
    int off;
    bit popping;
    old = m_pc;
    if (rst) begin
      model_reset();
      return;
    end
    popping = ld && (src == 2'b01);
    if (ld) begin
      case (src)
        2'b00: begin
          off = int'(ir[9:0]);
          if (ir[9]) off = off - 1024;
          m_pc = bra ? 16'(int'(old) + off) : {6'b0, ir[9:0]};
        end
        2'b01: begin
          if (m_stk.size() == 0) begin
            m_pc  = 16'h0;
            m_err = 1'b1;
          end else begin
            m_pc = m_stk[$];
          end
        end
        2'b10: m_pc = r1;
        default: m_pc = 16'h0;
      endcase
    end else if (inc) begin
      m_pc = old + 16'h1;
    end
    if (popping && stk) begin
      if (m_stk.size() == 0) m_stk.push_back(old);
      else m_stk[m_stk.size()-1] = old;
    end else if (popping) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
    end else if (stk) begin
      if (m_stk.size() == SD) m_err = 1'b1;
      else m_stk.push_back(old);
    end
  endtask

  task automatic op(
    input bit rst, input bit inc, input bit ld,
    input bit stk, input logic [1:0] src,
    input bit bra, input logic [15:0] ir,
    input logic [15:0] r1, input string nm);
    @(negedge Clk);
    Reset    = 1'b1;
    PC_Rst   = rst ? ASSERTED : DEASSERTED;
    PC_Inc   = inc ? ASSERTED : DEASSERTED;
    PC_Ld    = ld  ? ASSERTED : DEASSERTED;
    STK_Ld   = stk ? ASSERTED : DEASSERTED;
    PC_Src   = src;
    BRA_Src  = bra;
    IR       = ir;
    Reg_Src1 = r1;
    model_step(rst, inc, ld, stk, src, bra, ir, r1);
    push_exp(nm);
  endtask

  task automatic areset(input string nm);
    @(negedge Clk);
    PC_Rst = DEASSERTED;
    PC_Inc = DEASSERTED;
    PC_Ld  = DEASSERTED;
    STK_Ld = DEASSERTED;
    model_reset();
    push_exp(nm);
    Reset = 1'b0;
  endtask

  task automatic ld_reg(input logic [15:0] v, input string nm);
    op(0, 0, 1, 0, PCSRC_REG, 0, 16'h0, v, nm);
  endtask

  // Monitor: every rising Clk or async reset presents new state.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge Clk or negedge Reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({PC, STK_Top, STK_Full, STK_Empty, STK_Err} !== e) begin
          errors++;
          $display("FAIL %s: got pc=%h top=%h full=%b empty=%b err=%b, expected pc=%h top=%h full=%b empty=%b err=%b",
                   n, PC, STK_Top, STK_Full, STK_Empty, STK_Err,
                   e.pc, e.top, e.full, e.empty, e.err);
        end
      end
    end
  end

  initial begin
    areset("reset_init");

    ld_reg(16'h0123, "set_0123");
    op(0, 0, 0, 1, 2'b00, 0, 0, 0, "push_a");
    op(0, 1, 0, 0, 2'b00, 0, 0, 0, "inc_a");
    op(0, 0, 0, 1, 2'b00, 0, 0, 0, "push_b");
    areset("reset_midrun");

    ld_reg(16'h0010, "set_0010");
    op(0, 0, 1, 0, PCSRC_BRANCH, BRA_REL, 16'h03FE, 0, "branch_rel");
    ld_reg(16'h0010, "set_0010b");
    op(0, 0, 1, 0, PCSRC_BRANCH, BRA_ABS, 16'h03FE, 0, "branch_abs");

    ld_reg(16'h0021, "set_0021");
    op(0, 0, 1, 1, PCSRC_REG, 0, 0, 16'h0400, "jpl");
    op(0, 0, 1, 0, PCSRC_RETURN, 0, 0, 0, "ret");

    op(1, 0, 0, 0, 2'b00, 0, 0, 0, "pc_rst_a");
    for (int k = 1; k <= 5; k++) begin
      op(0, 1, 0, 0, 2'b00, 0, 0, 0, $sformatf("inc_%0d", k));
      op(0, 0, 0, 1, 2'b00, 0, 0, 0, $sformatf("push_%0d", k));
    end
    op(1, 0, 0, 0, 2'b00, 0, 0, 0, "pc_rst_clear");

    op(0, 0, 1, 0, PCSRC_RETURN, 0, 0, 0, "pop_empty");
    op(0, 1, 1, 0, PCSRC_REG, 0, 0, 16'h0050, "ld_beats_inc");

    ld_reg(16'hFFFF, "set_ffff");
    op(0, 1, 0, 0, 2'b00, 0, 0, 0, "inc_wrap");

    op(1, 0, 0, 1, 2'b00, 0, 0, 0, "pc_rst_ignores_push");
    ld_reg(16'h002D, "set_002d");
    op(0, 0, 0, 1, 2'b00, 0, 0, 0, "fill_1");
    for (int k = 2; k <= 4; k++) begin
      op(0, 1, 0, 0, 2'b00, 0, 0, 0, "fill_inc");
      op(0, 0, 0, 1, 2'b00, 0, 0, 0, $sformatf("fill_%0d", k));
    end
    ld_reg(16'h0100, "set_0100");
    op(0, 0, 1, 1, PCSRC_RETURN, 0, 0, 0, "swap_full");
    op(0, 0, 1, 0, PCSRC_VECTOR, 0, 0, 0, "ld_vector");
    op(0, 0, 1, 1, PCSRC_RETURN, 0, 0, 0, "swap_partial");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        areset("rand_areset");
      end else begin
        op($urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           16'($urandom),
           16'($urandom),
           "random");
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge Clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the sequence controller.
- Consumes PC_Rst/PC_Inc/PC_Ld/PC_Src/BRA_Src/STK_Ld and produces the fetch address on PC.
- Holds a small hardware return-address stack (JPL push / RET pop) and computes branch targets from the IR offset field.
- All control inputs are active-low strobes sampled on each rising Clk edge, matching controller polarity.

Parameters:
DataWidth, 16, width of PC, IR, register operand and stack entries
OffsetWidth, 10, width of branch offset field IR[OffsetWidth-1:0]
StackDepth, 4, number of return-address entries (power of 2, >=2)
ResetVector, 0, PC value after reset

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
PC_Rst  in  1  active-low synchronous PC reset to ResetVector
PC_Inc  in  1  active-low PC increment
PC_Ld  in  1  active-low PC load from source selected by PC_Src
PC_Src  in  2  00 branch target, 01 return (pop), 10 Reg_Src1, 11 ResetVector
BRA_Src  in  1  1: PC + sign-extended offset; 0: zero-extended offset (absolute)
STK_Ld  in  1  active-low push of current PC onto return stack
IR  in  DataWidth  instruction; low OffsetWidth bits are the branch offset
Reg_Src1  in  DataWidth  register-file source-1 value (JPL/JMP target)
PC  out  DataWidth  current program counter
STK_Top  out  DataWidth  top-of-stack entry; 0 when empty
STK_Full  out  1  stack holds StackDepth entries
STK_Empty  out  1  stack holds 0 entries
STK_Err  out  1  sticky: push on full or pop on empty

Behaviour:
- Reset low (async): PC=ResetVector, stack depth=0, all entries 0, STK_Empty=1, STK_Full=0, STK_Err=0, STK_Top=0.
- Register update occurs on every rising edge at which a strobe is low. Strobes held low for N edges act N times. The controller guarantees single-edge pulses.
- PC priority: PC_Rst > PC_Ld > PC_Inc > hold.
- PC_Rst low: PC=ResetVector, STK_Err cleared, stack depth=0. A simultaneous STK_Ld is ignored.
- PC_Inc: PC=PC+1, modulo 2^DataWidth; 0xFFFF wraps to 0x0000.
- PC_Ld source by PC_Src:
  - 00: BRA_Src=1 gives PC + sext(IR[OffsetWidth-1:0]); BRA_Src=0 gives zext(IR[OffsetWidth-1:0]). PC here is the pre-edge value, already pointing at the next instruction. Modulo arithmetic.
  - 01: PC=STK_Top and pop (depth-1). If empty: PC=ResetVector, depth stays 0, STK_Err=1.
  - 10: PC=Reg_Src1.
  - 11: PC=ResetVector.
- STK_Ld low: push the pre-edge PC, depth+1.
  - If full: push dropped, contents unchanged, STK_Err=1.
  - Push concurrent with PC_Ld (JPL case) stores the old PC, i.e. the return address, not the new target.
- Push and pop on the same edge (STK_Ld low, PC_Ld low, PC_Src=01):
  - PC=old top; top entry is overwritten with the old PC.
  - Depth unchanged. Legal even when full.
  - On empty: treated as a pop-on-empty (error, PC=ResetVector), and the push then proceeds into the empty stack (depth becomes 1).
- Latency: PC, STK_Top and flags are registered; all reflect the edge immediately. No combinational path from inputs to outputs.
- STK_Full and STK_Empty are derived from the depth register. STK_Err remains set until Reset or PC_Rst.

Decomposition:
- Shared package/include holds:
  - PC_Src encodings (PCSRC_BRANCH=2'b00, PCSRC_RETURN=2'b01, PCSRC_REG=2'b10, PCSRC_VECTOR=2'b11).
  - BRA_Src encodings.
  - Active-low strobe constants (ASSERTED=1'b0).
- Sub-module return_stack (params DataWidth, StackDepth):
  - Inputs: Clk, Reset, push, pop, push_data, clr.
  - Outputs: top, full, empty, err.
  - Implements the simultaneous push/pop and error rules.
- pc_unit contains the PC register, target adder and source mux.

Test Plan:
- Reset low mid-run with PC=0x0123 and depth 2 -> immediately PC=0x0000, STK_Empty=1, STK_Err=0, STK_Top=0.
- PC=0x0010, IR[9:0]=0x3FE, BRA_Src=1, PC_Src=00, PC_Ld pulse -> PC=0x000E. With BRA_Src=0 -> PC=0x03FE.
- JPL case: PC=0x0021, Reg_Src1=0x0400, PC_Src=10, PC_Ld and STK_Ld pulsed together -> PC=0x0400, STK_Top=0x0021. Then PC_Src=01 PC_Ld pulse -> PC=0x0021, STK_Empty=1.
- Five pushes at PC=1..5 (PC_Inc between) with StackDepth=4 -> STK_Full=1 after 4th, 5th sets STK_Err=1, STK_Top=0x0004. Then a PC_Rst pulse clears STK_Err and the stack.
- Pop on empty -> PC=0x0000, STK_Err=1. Then PC_Inc and PC_Ld together with PC_Src=10, Reg_Src1=0x0050 -> PC=0x0050 (load wins).
- PC=0xFFFF, PC_Inc pulse -> PC=0x0000. Simultaneous push/pop on full stack with top 0x0030, PC=0x0100 -> PC=0x0030, STK_Top=0x0100, STK_Full=1, STK_Err unchanged.
